operand_fetch: RTL
==================

Name: operand_fetch

Overview:
Decode/operand-fetch stage that sits directly upstream of the 32x32 register file. It drives the file's two read addresses from the incoming instruction and captures both read values plus a generated immediate into one pipeline register for the execute stage. A per-register busy scoreboard, cleared by writeback, stalls RAW and WAW hazards. Valid/ready handshakes on both sides.

Parameters:
XLEN, 32, data/PC width
RESET_PC, 32'h0, value held in out_pc while in reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  instruction present
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  32  RV32I instruction word
in_pc  in  XLEN  PC of in_instr
A1  out  5  register-file read address 1 = in_instr[19:15]
A2  out  5  register-file read address 2 = in_instr[24:20]
RD1  in  XLEN  register-file read data 1 (combinational)
RD2  in  XLEN  register-file read data 2 (combinational)
wb_valid  in  1  writeback retiring a register write this cycle
wb_rd  in  5  register being written by writeback
flush  in  1  discard output-register contents
out_valid  out  1  bundle valid
out_ready  in  1  execute consumes bundle
out_pc, out_rs1_val, out_rs2_val, out_imm  out  XLEN  captured PC, RD1, RD2, immediate
out_rd  out  5  destination = instr[11:7]
out_opcode  out  7  instr[6:0]
out_funct3  out  3  instr[14:12]
out_funct7b5  out  1  instr[30]
out_writes_rd  out  1  instruction writes rd and rd != 0
out_illegal  out  1  opcode not in supported set

Behaviour:
- Reset (async, active-high): out_valid=0, all busy bits=0, every output register=0 except out_pc=RESET_PC. in_ready=0 while reset is high.
- A1/A2: purely combinational from in_instr, regardless of in_valid.
- Decode (combinational on in_instr):
  - I-type opcodes 0010011, 0000011, 1100111: imm = sext(instr[31:20]).
  - S 0100011: sext({instr[31:25], instr[11:7]}).
  - B 1100011: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U 0110111/0010111: {instr[31:12], 12'b0}.
  - J 1101111: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R 0110011: imm=0.
  - Any other opcode: illegal=1, imm=0, writes_rd=0, uses_rs1=uses_rs2=0.
- Source/destination use: uses_rs1 for all except U/J; uses_rs2 for R/S/B only; writes_rd for R/I/U/J when rd != 0.
- hazard = (uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]) | (writes_rd & busy[rd]).
  - busy[0] is hardwired 0.
  - No bypass: a register cleared by wb in the same cycle still counts as busy this cycle; issue proceeds next cycle.
- in_ready = !reset & !flush & !hazard & (!out_valid | out_ready). fire = in_valid & in_ready.
- Output register, per rising edge, in priority order:
  - flush: out_valid <= 0.
  - else fire: capture all out_* fields, out_valid <= 1.
  - else out_ready: out_valid <= 0.
  - else hold all fields.
- Held bundle: fields must remain stable while out_valid & !out_ready. Latency in_valid to out_valid is 1 cycle.
- Scoreboard, per edge:
  - wb_valid clears busy[wb_rd].
  - fire & writes_rd sets busy[rd]. Set wins over a same-cycle clear of the same index.
  - flush with out_valid & out_writes_rd clears busy[out_rd]. This also wins over set; no set occurs because fire=0 during flush.
- Busy is never set twice for one register because WAW stalls.
- wb_valid for a non-busy register is ignored (no error).

Test Plan:
- Reset mid-stream with out_valid=1 and busy[5]=1 -> out_valid=0 and busy all 0 immediately (asynchronously); in_ready=1 on the first cycle after release with out_ready=1.
- addi x5,x0,7 (0x00700293), out_ready=1 -> A1=0, next cycle out_valid=1, out_imm=7, out_rd=5, out_writes_rd=1; busy[5]=1.
- Then add x6,x5,x5 (0x00528333) -> in_ready=0. wb_valid with wb_rd=5 in cycle N -> still stalled in N, accepted in N+1, out_rs1_val=out_rs2_val=RD1/RD2 sampled at N+1.
- sw x6,8(x2) (0x00612423) -> out_imm=8, out_writes_rd=0, A1=2, A2=6, no busy bit set. beq x0,x0,-4 (0xFE000EE3) -> out_imm=0xFFFFFFFC.
- lui x7,0x12345 (0x123453B7) with out_ready=0 for 3 cycles -> bundle stable, in_ready=0. Then flush -> out_valid=0, busy[7]=0 next cycle.
- Opcode 0x0000007F -> out_illegal=1, out_writes_rd=0; no stall even when busy[rs1] is set.

Source files
------------

// File: rtl/operand_fetch.sv
`timescale 1ns/1ps
// operand_fetch
//   Decode / operand-fetch stage in front of a 32x32 register file. Drives the
//   two read addresses straight from the incoming instruction, decodes the
//   immediate and register usage, and captures RD1/RD2/imm plus decoded fields
//   into a single output register. A per-register busy scoreboard (set on
//   issue of a register-writing instruction, cleared by writeback) stalls RAW
//   and WAW hazards. There is no bypass from writeback.
//
// Ports
//   clk, reset            clock, async active-high reset
//   in_valid/in_ready     upstream handshake; in_instr, in_pc instruction + PC
//   A1, A2                register-file read addresses (rs1, rs2)
//   RD1, RD2              register-file read data (combinational)
//   wb_valid, wb_rd       writeback retiring a write to register wb_rd
//   flush                 drop the output bundle
//   out_valid/out_ready   downstream handshake
//   out_*                 captured bundle for the execute stage
module operand_fetch #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      A1,
  output logic [4:0]      A2,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_writes_rd,
  output logic            out_illegal
);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_uses_rs1, w_uses_rs2, w_wr_type, w_illegal;
  logic            w_writes_rd, w_hazard, w_fire;
  logic [31:0]     r_busy, w_busy_nxt;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc, r_out_rs1_val, r_out_rs2_val, r_out_imm;
  logic [4:0]      r_out_rd;
  logic [6:0]      r_out_opcode;
  logic [2:0]      r_out_funct3;
  logic            r_out_funct7b5, r_out_writes_rd, r_out_illegal;

  assign w_opcode = in_instr[6:0];
  assign w_rs1    = in_instr[19:15];
  assign w_rs2    = in_instr[24:20];
  assign w_rd     = in_instr[11:7];
  assign A1       = w_rs1;
  assign A2       = w_rs2;

  always_comb begin
    w_imm32    = '0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_wr_type  = 1'b0;
    w_illegal  = 1'b0;
    case (w_opcode)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w_imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
        w_uses_rs1 = 1'b1;
        w_wr_type  = 1'b1;
      end
      7'b0100011: begin
        w_imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      7'b1100011: begin
        w_imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        w_imm32   = {in_instr[31:12], 12'b0};
        w_wr_type = 1'b1;
      end
      7'b1101111: begin
        w_imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
        w_wr_type = 1'b1;
      end
      7'b0110011: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
        w_wr_type  = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_imm       = XLEN'($signed(w_imm32));
  assign w_writes_rd = w_wr_type & (w_rd != 5'd0);

  // Busy is looked up from the registered scoreboard only: a same-cycle
  // writeback does not unblock issue until the following cycle.
  assign w_hazard = (w_uses_rs1 & r_busy[w_rs1]) |
                    (w_uses_rs2 & r_busy[w_rs2]) |
                    (w_writes_rd & r_busy[w_rd]);

  assign in_ready = !reset & !flush & !w_hazard & (!r_out_valid | out_ready);
  assign w_fire   = in_valid & in_ready;

  // Ordering gives set priority over writeback clear, and flush-clear priority
  // over both (set cannot coincide with flush since fire is 0 then).
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid)
      w_busy_nxt[wb_rd] = 1'b0;
    if (w_fire && w_writes_rd)
      w_busy_nxt[w_rd] = 1'b1;
    if (flush && r_out_valid && r_out_writes_rd)
      w_busy_nxt[r_out_rd] = 1'b0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid     <= 1'b0;
      r_out_pc        <= RESET_PC;
      r_out_rs1_val   <= '0;
      r_out_rs2_val   <= '0;
      r_out_imm       <= '0;
      r_out_rd        <= '0;
      r_out_opcode    <= '0;
      r_out_funct3    <= '0;
      r_out_funct7b5  <= 1'b0;
      r_out_writes_rd <= 1'b0;
      r_out_illegal   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out_valid     <= 1'b1;
      r_out_pc        <= in_pc;
      r_out_rs1_val   <= RD1;
      r_out_rs2_val   <= RD2;
      r_out_imm       <= w_imm;
      r_out_rd        <= w_rd;
      r_out_opcode    <= w_opcode;
      r_out_funct3    <= in_instr[14:12];
      r_out_funct7b5  <= in_instr[30];
      r_out_writes_rd <= w_writes_rd;
      r_out_illegal   <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_pc        = r_out_pc;
  assign out_rs1_val   = r_out_rs1_val;
  assign out_rs2_val   = r_out_rs2_val;
  assign out_imm       = r_out_imm;
  assign out_rd        = r_out_rd;
  assign out_opcode    = r_out_opcode;
  assign out_funct3    = r_out_funct3;
  assign out_funct7b5  = r_out_funct7b5;
  assign out_writes_rd = r_out_writes_rd;
  assign out_illegal   = r_out_illegal;

endmodule
